// File: rtl/cell_vector_tester_pkg.sv
// Shared definitions for the cell vector tester: register map, bit positions,
// FSM state encoding and the byte-lane write mask helper.
package cell_vector_tester_pkg;

  // Word indices into the register block (byte offset / 4)
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STIM   = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_RESP   = 3'd3;
  localparam logic [2:0] REG_SIG    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_SEED   = 3'd6;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_MODE    = 2;
  localparam int unsigned STATUS_BUSY  = 0;
  localparam int unsigned STATUS_DONE  = 1;

  localparam logic [31:0] DEFAULT_MISR_POLY = 32'h0040_0007;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/cell_vector_tester_if.sv
// Wishbone slave bus bundle for the cell vector tester register block.
interface cell_vector_tester_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/cell_vector_tester_misr32.sv
// Combinational next-state of a 32-bit multiple-input signature register.
module misr32 (
  input  logic [31:0] sig,
  input  logic [31:0] data,
  input  logic [31:0] poly,
  output logic [31:0] sig_next
);
  assign sig_next = ({sig[30:0], 1'b0} ^ (sig[31] ? poly : '0)) ^ data;
endmodule

// File: rtl/cell_vector_tester.sv
// Wishbone-controlled stimulus/response engine: applies vectors to the cell
// array, waits a settle time, captures responses and compacts them in a MISR.
module cell_vector_tester
  import cell_vector_tester_pkg::*;
#(
  parameter int unsigned STIM_W    = 16,
  parameter int unsigned RESP_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] MISR_POLY = DEFAULT_MISR_POLY
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  cell_vector_tester_if.slave  wbs,
  output logic [STIM_W-1:0]    stim_o,
  input  logic [RESP_W-1:0]    resp_i,
  output logic                 busy_o,
  output logic                 done_irq_o
);

  state_t state, state_next;

  logic              ack, access, wr_en, rd_en;
  logic [2:0]        offset;
  logic [31:0]       wmask, dat, rdata, rdat_q;
  logic              start_wr, abort_wr, w1c_done, start_p, abort_p;
  logic              mode_q, run_mode, done_q;
  logic [7:0]        settle_q, run_settle, settle_cnt;
  logic [STIM_W-1:0] stim_q, cur;
  logic [15:0]       count_q, run_count, vcnt;
  logic [RESP_W-1:0] resp_q;
  logic [31:0]       sig_q, sig_next, seed_q, resp_ext;
  logic              start_accept, capture, last_vec, done_set;
  logic              unused_adr;

  assign unused_adr = ^{wbs.wbs_adr_i[7:5], wbs.wbs_adr_i[1:0]};

  assign access = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack
                & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr_en  = access & wbs.wbs_we_i;
  assign rd_en  = access & ~wbs.wbs_we_i;
  assign offset = wbs.wbs_adr_i[4:2];
  assign wmask  = sel_mask(wbs.wbs_sel_i);
  assign dat    = wbs.wbs_dat_i;

  assign start_wr = wr_en & (offset == REG_CTRL) & wbs.wbs_sel_i[0] & dat[CTRL_START];
  assign abort_wr = wr_en & (offset == REG_CTRL) & wbs.wbs_sel_i[0] & dat[CTRL_ABORT];
  assign w1c_done = wr_en & (offset == REG_STATUS) & wbs.wbs_sel_i[0] & dat[STATUS_DONE];

  assign wbs.wbs_ack_o = ack;
  assign wbs.wbs_dat_o = rdat_q;
  assign busy_o        = (state != ST_IDLE);
  assign done_irq_o    = done_q;
  assign resp_ext      = 32'(resp_i);

  misr32 u_misr (
    .sig      (sig_q),
    .data     (resp_ext),
    .poly     (MISR_POLY),
    .sig_next (sig_next)
  );

  always_comb begin
    rdata = '0;
    case (offset)
      REG_CTRL: begin
        rdata[CTRL_MODE] = mode_q;
        rdata[15:8]      = settle_q;
      end
      REG_STIM:   rdata[STIM_W-1:0] = stim_q;
      REG_COUNT:  rdata[15:0]       = count_q;
      REG_RESP:   rdata[RESP_W-1:0] = resp_q;
      REG_SIG:    rdata             = sig_q;
      REG_STATUS: begin
        rdata[STATUS_BUSY] = busy_o;
        rdata[STATUS_DONE] = done_q;
        rdata[31:16]       = vcnt;
      end
      REG_SEED:   rdata = seed_q;
      default:    rdata = '0;
    endcase
  end

  // Commands are registered, so a START/ABORT acts one cycle after its ack edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack      <= 1'b0;
      rdat_q   <= '0;
      start_p  <= 1'b0;
      abort_p  <= 1'b0;
      mode_q   <= 1'b0;
      settle_q <= '0;
      stim_q   <= '0;
      count_q  <= '0;
      seed_q   <= '0;
    end else begin
      ack     <= access;
      rdat_q  <= rd_en ? rdata : '0;
      start_p <= start_wr & ~abort_wr;
      abort_p <= abort_wr;
      if (wr_en) begin
        case (offset)
          REG_CTRL: begin
            if (wbs.wbs_sel_i[0]) mode_q <= dat[CTRL_MODE];
            settle_q <= (settle_q & ~wmask[15:8]) | (dat[15:8] & wmask[15:8]);
          end
          REG_STIM:  stim_q  <= (stim_q & ~wmask[STIM_W-1:0]) | (dat[STIM_W-1:0] & wmask[STIM_W-1:0]);
          REG_COUNT: count_q <= (count_q & ~wmask[15:0]) | (dat[15:0] & wmask[15:0]);
          REG_SEED:  seed_q  <= (seed_q & ~wmask) | (dat & wmask);
          default: ;
        endcase
      end
    end
  end

  assign start_accept = start_p & (state == ST_IDLE);
  assign capture      = (state == ST_CAPTURE) & ~abort_p;
  assign last_vec     = ~run_mode | (({1'b0, vcnt} + 17'd1) == {1'b0, run_count});
  assign done_set     = (start_accept & mode_q & (count_q == '0)) | (capture & last_vec);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start_p && !(mode_q && count_q == '0)) state_next = ST_APPLY;
      ST_APPLY:   state_next = ST_WAIT;
      ST_WAIT:    if (settle_cnt == '0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = last_vec ? ST_IDLE : ST_APPLY;
      default:    state_next = ST_IDLE;
    endcase
    if (abort_p && state != ST_IDLE) state_next = ST_IDLE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stim_o     <= '0;
      cur        <= '0;
      run_mode   <= 1'b0;
      run_settle <= '0;
      run_count  <= '0;
      settle_cnt <= '0;
      resp_q     <= '0;
      sig_q      <= '0;
      vcnt       <= '0;
      done_q     <= 1'b0;
    end else begin
      if (start_accept) begin
        sig_q      <= seed_q;
        vcnt       <= '0;
        cur        <= stim_q;
        run_mode   <= mode_q;
        run_settle <= settle_q;
        run_count  <= count_q;
      end
      if (state == ST_APPLY && !abort_p) begin
        stim_o     <= cur;
        settle_cnt <= run_settle;
      end
      if (state == ST_WAIT && settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
      if (capture) begin
        resp_q <= resp_i;
        sig_q  <= sig_next;
        if (vcnt != 16'hFFFF) vcnt <= vcnt + 16'd1;
        if (!last_vec) cur <= cur + 1'b1;
      end
      // A completion in the same cycle as a clear keeps DONE set
      done_q <= done_set | (done_q & ~(start_accept | w1c_done));
    end
  end

endmodule

// File: tb/tb_cell_vector_tester.sv
// Scoreboarded random/directed bench for cell_vector_tester with a
// vector-level reference model of the run sequence and MISR signature.
module tb_cell_vector_tester;

  localparam int unsigned STIM_W = 16;
  localparam int unsigned RESP_W = 16;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] POLY   = 32'h0040_0007;

  localparam logic [7:0] O_CTRL = 8'h00, O_STIM = 8'h04, O_COUNT = 8'h08, O_RESP = 8'h0C;
  localparam logic [7:0] O_SIG  = 8'h10, O_STATUS = 8'h14, O_SEED = 8'h18;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [STIM_W-1:0] stim;
  logic [RESP_W-1:0] resp;
  logic              busy, irq;
  logic [15:0]       xmask = '0;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb_q[$];
  string       sb_name[$];
  logic [15:0] exp_stim[$];

  cell_vector_tester_if bus ();

  assign resp = stim ^ xmask;

  cell_vector_tester #(
    .STIM_W    (STIM_W),
    .RESP_W    (RESP_W),
    .BASE_ADDR (BASE),
    .MISR_POLY (POLY)
  ) u_dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs        (bus),
    .stim_o     (stim),
    .resp_i     (resp),
    .busy_o     (busy),
    .done_irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected transaction and checks read data
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wbs_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        string       n;
        e = sb_q.pop_front();
        n = sb_name.pop_front();
        if (e[32]) check(n, bus.wbs_dat_o, e[31:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] d,
                           input logic [3:0] sel, input bit exp_ack,
                           input logic [31:0] exp_rd, input string name);
    if (exp_ack) begin
      sb_q.push_back({~we, exp_rd});
      sb_name.push_back(name);
    end
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = sel;
    @(negedge clk);
    check({name, "_ack"}, 32'(bus.wbs_ack_o), 32'(exp_ack));
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge clk);
    check({name, "_ack_low"}, 32'(bus.wbs_ack_o), 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    wb_access(1'b1, BASE | 32'(off), d, 4'hF, 1'b1, 32'd0, "wr");
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    wb_access(1'b0, BASE | 32'(off), 32'd0, 4'hF, 1'b1, exp, name);
  endtask

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] fb;
    fb = s[31] ? POLY : 32'd0;
    return ((s << 1) ^ fb) ^ d;
  endfunction

  // Vector-level model of one run: the list of applied values and the
  // signature/response after all captures
  task automatic model(input bit mode, input logic [31:0] seed, input logic [15:0] first,
                       input logic [15:0] count, output logic [31:0] sig,
                       output logic [15:0] last_resp, output int n);
    logic [15:0] v, r;
    n = mode ? int'(count) : 1;
    sig = seed;
    last_resp = '0;
    v = first;
    exp_stim.delete();
    for (int i = 0; i < n; i++) begin
      exp_stim.push_back(v);
      r = v ^ xmask;
      sig = misr_step(sig, {16'd0, r});
      last_resp = r;
      v = v + 16'd1;
    end
  endtask

  // Called at the negedge of the first busy cycle (right after a START write)
  task automatic run_and_check(input int n, input int p);
    int t;
    check("busy_start", 32'(busy), 32'd1);
    t = 1;
    for (int v = 0; v < n; v++) begin
      step(2 + v * p - t);
      t = 2 + v * p;
      check("stim_seq", 32'(stim), 32'(exp_stim[v]));
    end
    step(n * p - t);
    check("busy_last", 32'(busy), 32'd1);
    step(1);
    check("busy_end", 32'(busy), 32'd0);
    check("irq_done", 32'(irq), 32'd1);
  endtask

  initial begin
    logic [31:0] esig, seed, d;
    logic [15:0] eresp, st, cnt;
    int          n, s;
    bit          mode;

    rst_n = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    step(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Reset in the middle of a long sweep
    wr(O_SEED, 32'h0000_5555);
    wr(O_STIM, 32'h0000_1234);
    wr(O_COUNT, 32'd10);
    wr(O_CTRL, 32'h0000_1405);
    step(5);
    check("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_stim", 32'(stim), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 8; i++) rd(8'(i * 4), 32'd0, "post_reset_read");

    // Decode: miss, unmapped offset, byte enables, stim width
    wb_access(1'b1, 32'h4000_0018, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0, "miss_wr");
    wb_access(1'b0, 32'h4000_0000, 32'd0, 4'hF, 1'b0, 32'd0, "miss_rd");
    rd(O_SEED, 32'd0, "seed_after_miss");
    wr(8'h1C, 32'hFFFF_FFFF);
    rd(8'h1C, 32'd0, "unmapped");
    wr(O_SEED, 32'h1122_3344);
    wb_access(1'b1, BASE | 32'(O_SEED), 32'hAABB_CCDD, 4'b0101, 1'b1, 32'd0, "wr_sel");
    rd(O_SEED, 32'h11BB_33DD, "seed_sel");
    wr(O_STIM, 32'hDEAD_BEEF);
    rd(O_STIM, 32'h0000_BEEF, "stim_width");

    // Single vector, loopback
    xmask = '0;
    wr(O_SEED, 32'd0);
    wr(O_STIM, 32'h0000_00A5);
    model(1'b0, 32'd0, 16'h00A5, 16'd0, esig, eresp, n);
    wr(O_CTRL, 32'h0000_0201);
    run_and_check(n, 5);
    rd(O_RESP, 32'h0000_00A5, "single_resp");
    rd(O_SIG, 32'h0000_00A5, "single_sig");
    rd(O_STATUS, 32'h0001_0002, "single_status");
    rd(O_CTRL, 32'h0000_0200, "ctrl_readback");

    // Sweep of four vectors
    wr(O_SEED, 32'hFFFF_FFFF);
    wr(O_STIM, 32'd0);
    wr(O_COUNT, 32'd4);
    model(1'b1, 32'hFFFF_FFFF, 16'd0, 16'd4, esig, eresp, n);
    wr(O_CTRL, 32'h0000_0005);
    run_and_check(n, 3);
    rd(O_SIG, esig, "sweep_sig");
    rd(O_RESP, 32'(eresp), "sweep_resp");
    rd(O_STATUS, 32'h0004_0002, "sweep_status");

    // Wrap of the stimulus counter
    wr(O_SEED, 32'h0000_0001);
    wr(O_STIM, 32'h0000_FFFE);
    wr(O_COUNT, 32'd3);
    model(1'b1, 32'h0000_0001, 16'hFFFE, 16'd3, esig, eresp, n);
    wr(O_CTRL, 32'h0000_0105);
    run_and_check(n, 4);
    rd(O_SIG, esig, "wrap_sig");
    rd(O_STATUS, 32'h0003_0002, "wrap_status");

    // DONE clear, then empty sweep
    wr(O_STATUS, 32'h0000_0002);
    check("w1c_irq", 32'(irq), 32'd0);
    rd(O_STATUS, 32'h0003_0000, "w1c_status");
    wr(O_COUNT, 32'd0);
    wr(O_CTRL, 32'h0000_0005);
    check("count0_busy", 32'(busy), 32'd0);
    check("count0_irq", 32'(irq), 32'd1);
    step(1);
    check("count0_busy2", 32'(busy), 32'd0);
    rd(O_STATUS, 32'h0000_0002, "count0_status");

    // Abort during WAIT of the second vector
    wr(O_SEED, 32'h0BAD_F00D);
    wr(O_STIM, 32'h0000_0100);
    wr(O_COUNT, 32'd10);
    model(1'b1, 32'h0BAD_F00D, 16'h0100, 16'd1, esig, eresp, n);
    wr(O_CTRL, 32'h0000_0505);
    check("abort_busy_pre", 32'(busy), 32'd1);
    step(9);
    wr(O_CTRL, 32'h0000_0506);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_irq", 32'(irq), 32'd0);
    check("abort_stim_hold", 32'(stim), 32'h0000_0101);
    rd(O_STATUS, 32'h0001_0000, "abort_status");
    rd(O_RESP, 32'(eresp), "abort_resp");
    rd(O_SIG, esig, "abort_sig");

    // START while busy must not restart; the run keeps its latched MODE
    wr(O_COUNT, 32'd3);
    wr(O_CTRL, 32'h0000_0105);
    step(2);
    wr(O_CTRL, 32'h0000_0101);
    step(7);
    check("restart_busy_last", 32'(busy), 32'd1);
    step(1);
    check("restart_busy_end", 32'(busy), 32'd0);
    rd(O_STATUS, 32'h0003_0002, "restart_status");
    rd(O_CTRL, 32'h0000_0100, "restart_ctrl");

    // START and ABORT together: no run, DONE and VCNT untouched
    wr(O_CTRL, 32'h0000_0107);
    check("startabort_busy", 32'(busy), 32'd0);
    step(1);
    check("startabort_busy2", 32'(busy), 32'd0);
    rd(O_STATUS, 32'h0003_0002, "startabort_status");
    rd(O_CTRL, 32'h0000_0104, "startabort_ctrl");

    // W1C landing on the final capture edge: set wins
    wr(O_CTRL, 32'h0000_0301);
    step(5);
    wr(O_STATUS, 32'h0000_0002);
    check("collide_irq", 32'(irq), 32'd1);
    rd(O_STATUS, 32'h0001_0002, "collide_status");
    wr(O_STATUS, 32'h0000_0002);
    check("clear_irq", 32'(irq), 32'd0);

    // Randomized runs against the model
    for (int it = 0; it < 10; it++) begin
      seed  = $urandom;
      d     = $urandom;
      st    = d[15:0];
      cnt   = 16'($urandom_range(1, 5));
      s     = int'($urandom_range(0, 3));
      mode  = 1'($urandom_range(0, 1));
      d     = $urandom;
      xmask = d[15:0];
      wr(O_SEED, seed);
      wr(O_STIM, {16'd0, st});
      wr(O_COUNT, {16'd0, cnt});
      model(mode, seed, st, cnt, esig, eresp, n);
      wr(O_CTRL, (32'(s) << 8) | (32'(mode) << 2) | 32'd1);
      run_and_check(n, s + 3);
      rd(O_RESP, 32'(eresp), "rand_resp");
      rd(O_SIG, esig, "rand_sig");
      rd(O_STATUS, (32'(n) << 16) | 32'd2, "rand_status");
    end

    step(2);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
